// File: rtl/thermo_encdr_if.sv
// Request/result bundle for the thermometer-code encoder.
interface thermo_encdr_if #(
    parameter int N  = 15,
    parameter int CW = 4
);
    logic          start;
    logic [N-1:0]  therm_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          err;

    modport master (output start, therm_in, input busy, done, count, err);
    modport slave  (input start, therm_in, output busy, done, count, err);
endinterface

// File: rtl/thermo_encdr.sv
// Bit-serial thermometer-code encoder: captures a code, scans one bit per
// clock, and reports the popcount plus a flag for non-thermometer codes.
module thermo_encdr #(
    parameter int N  = 15,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    thermo_encdr_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t        state, next_state;
    logic [N-1:0]  shadow;
    logic [CW-1:0] idx, ones, count_q;
    logic          seen_zero, err_flag, err_q, done_q;
    logic          bit_cur, last, err_nxt;
    logic [CW-1:0] ones_nxt;

    // Shadow shifts right each scan step, so the bit under test is always bit 0.
    assign bit_cur = shadow[0];
    assign last    = (idx == CW'(N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SCAN;
            SCAN:    if (last)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ones_nxt = ones + {{(CW-1){1'b0}}, bit_cur};
        err_nxt  = err_flag | (bit_cur & seen_zero);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow    <= '0;
            idx       <= '0;
            ones      <= '0;
            seen_zero <= 1'b0;
            err_flag  <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    shadow    <= bus.therm_in;
                    idx       <= '0;
                    ones      <= '0;
                    seen_zero <= 1'b0;
                    err_flag  <= 1'b0;
                end
                SCAN: begin
                    shadow   <= shadow >> 1;
                    idx      <= idx + 1'b1;
                    ones     <= ones_nxt;
                    err_flag <= err_nxt;
                    if (!bit_cur) seen_zero <= 1'b1;
                    if (last) begin
                        count_q <= ones_nxt;
                        err_q   <= err_nxt;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == SCAN);
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_thermo_encdr.sv
// Bench for thermo_encdr: directed and randomized codes against a popcount /
// legality reference model.
module tb_thermo_encdr;
    localparam int N  = 15;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    thermo_encdr_if #(.N(N), .CW(CW)) bus ();
    thermo_encdr #(.N(N), .CW(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    function automatic int model_count(input logic [N-1:0] code);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(code[i]);
        return s;
    endfunction

    // A legal code is k ones packed from bit 0 upward.
    function automatic logic model_err(input logic [N-1:0] code);
        int k = model_count(code);
        logic [N:0] legal = (17'(1) << k) - 17'(1);
        return code != legal[N-1:0];
    endfunction

    task automatic encode(input logic [N-1:0] code, input bit scramble,
                          output logic [CW-1:0] c, output logic e,
                          output int lat, output int busy_bad);
        @(negedge clk);
        bus.therm_in = code;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int i = 1; i <= N + 5; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = i; break; end
            if (!bus.busy) busy_bad++;
            if (scramble) begin
                bus.start    = 1'($urandom);
                bus.therm_in = N'($urandom);
            end
        end
        bus.start = 1'b0;
        c = bus.count;
        e = bus.err;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.therm_in = '0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.count, bus.err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b count=%0d err=%b want all 0",
                     bus.busy, bus.done, bus.count, bus.err);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.count, bus.err} !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b done=%b count=%0d err=%b want all 0",
                     bus.busy, bus.done, bus.count, bus.err);
        end
    endtask

    task automatic test_directed;
        logic [N-1:0] codes [5] = '{15'h007F, 15'h7FFF, 15'h0000, 15'h0005, 15'h4000};
        logic [CW-1:0] c;
        logic e;
        int lat, bb;
        for (int i = 0; i < 5; i++) begin
            encode(codes[i], 1'b0, c, e, lat, bb);
            n_cmp++;
            if (lat != N + 1 || bb != 0 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dir_timing[%h]: lat=%0d busy_low=%0d busy_at_done=%b want lat=%0d 0 0",
                         codes[i], lat, bb, bus.busy, N + 1);
            end
            n_cmp++;
            if (c !== CW'(model_count(codes[i])) || e !== model_err(codes[i])) begin
                n_bad++;
                $display("FAIL dir_result[%h]: count=%0d err=%b want %0d %b",
                         codes[i], c, e, model_count(codes[i]), model_err(codes[i]));
            end
            @(negedge clk);
            n_cmp++;
            if (bus.done !== 1'b0 || bus.count !== c) begin
                n_bad++;
                $display("FAIL dir_pulse[%h]: done=%b count=%0d want done=0 count held %0d",
                         codes[i], bus.done, bus.count, c);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] code;
        logic [CW-1:0] c;
        logic e;
        int lat, bb;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) code = N'((32'd1 << $urandom_range(N, 0)) - 1);
            else            code = N'($urandom);
            encode(code, i % 3 == 0, c, e, lat, bb);
            n_cmp++;
            if (lat != N + 1 || bb != 0 || c !== CW'(model_count(code)) || e !== model_err(code)) begin
                n_bad++;
                $display("FAIL rand[%0d] code=%h: lat=%0d busy_low=%0d count=%0d err=%b want lat=%0d 0 %0d %b",
                         i, code, lat, bb, c, e, N + 1, model_count(code), model_err(code));
            end
        end
    endtask

    task automatic test_ignore_inputs;
        int dones = 0;
        logic [CW-1:0] c = '1;
        logic e = 1'b1;
        @(negedge clk);
        bus.therm_in = 15'h000F;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 1; i <= N + 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin dones++; c = bus.count; e = bus.err; end
            if (i == 3) bus.therm_in = 15'h7FFF;
            if (i == 5) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (dones != 1 || c !== 4'd4 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_inputs: dones=%0d count=%0d err=%b want 1 4 0", dones, c, e);
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        logic [CW-1:0] c;
        logic e;
        int lat, bb;
        @(negedge clk);
        bus.therm_in = 15'h00FF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.count, bus.err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b count=%0d err=%b want all 0",
                     bus.busy, bus.done, bus.count, bus.err);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL reset_abort: activity cycles=%0d want 0", dones);
        end
        encode(15'h0003, 1'b0, c, e, lat, bb);
        n_cmp++;
        if (lat != N + 1 || bb != 0 || c !== 4'd2 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fresh: lat=%0d busy_low=%0d count=%0d err=%b want %0d 0 2 0",
                     lat, bb, c, e, N + 1);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        @(negedge clk);
        bus.therm_in = '0;
        bus.start = 1'b1;
        for (int k = 0; k <= N; k++) begin
            gap = -1;
            for (int i = 1; i <= N + 5; i++) begin
                @(negedge clk);
                if (bus.done) begin gap = i; break; end
            end
            n_cmp++;
            if (gap != N + 1 || bus.count !== CW'(k) || bus.err !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b[%0d]: gap=%0d count=%0d err=%b want %0d %0d 0",
                         k, gap, bus.count, bus.err, N + 1, k);
            end
            bus.therm_in = N'((32'd1 << (k + 1)) - 1);
        end
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_inputs;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
